// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the data memory.
// The master side is the requesters plus memory; the slave side is the arbiter.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  req0;
    logic                  req1;
    logic                  we0;
    logic                  we1;
    logic [ADDR_W-1:0]     adr0;
    logic [ADDR_W-1:0]     adr1;
    logic [DATA_W-1:0]     wdata0;
    logic [DATA_W-1:0]     wdata1;
    logic [DATA_W/8-1:0]   mask0;
    logic [DATA_W/8-1:0]   mask1;
    logic                  gnt0;
    logic                  gnt1;
    logic                  rvalid0;
    logic                  rvalid1;
    logic [DATA_W-1:0]     rdata0;
    logic [DATA_W-1:0]     rdata1;
    logic                  err0;
    logic                  err1;
    logic                  mrd;
    logic                  mwr;
    logic [ADDR_W-1:0]     adr;
    logic [DATA_W-1:0]     d_in;
    logic [DATA_W/8-1:0]   data_out_mask;
    logic [DATA_W-1:0]     d_out;

    modport master (
        output req0, req1, we0, we1, adr0, adr1, wdata0, wdata1, mask0, mask1, d_out,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, err0, err1,
        input  mrd, mwr, adr, d_in, data_out_mask
    );

    modport slave (
        input  req0, req1, we0, we1, adr0, adr1, wdata0, wdata1, mask0, mask1, d_out,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, err0, err1,
        output mrd, mwr, adr, d_in, data_out_mask
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter and IDLE/ACCESS/RESP sequencer for the data memory.
// Optional mask/alignment checking is enabled with `define DMEM_ARB_ALIGN_CHK_EN.
module dmem_arbiter #(
    parameter int          ADDR_W     = 32,
    parameter int          DATA_W     = 32,
    parameter int unsigned ADDR_LIMIT = 32'd65532
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  bus
);
    localparam int MASK_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } state_t;

    state_t              state_q, state_d;
    logic                last_q, last_d;
    logic                port_q, port_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   adr_q, adr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [MASK_W-1:0]   mask_q, mask_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic                any_req_s;
    logic                win_s;
    logic                sup_s;

`ifdef DMEM_ARB_ALIGN_CHK_EN
    function automatic logic align_bad(input logic [MASK_W-1:0] m, input logic [1:0] a);
        logic bad;
        case (m)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: bad = 1'b0;
            4'b0011, 4'b1100:                   bad = a[0];
            4'b1111:                            bad = |a;
            default:                            bad = 1'b1;
        endcase
        return bad;
    endfunction
`endif

    // Winner selection and suppression of the latched access.
    always_comb begin
        any_req_s = bus.req0 | bus.req1;
        if (bus.req0 && bus.req1) begin
            win_s = ~last_q;
        end else begin
            win_s = bus.req1;
        end
`ifdef DMEM_ARB_ALIGN_CHK_EN
        sup_s = (adr_q > ADDR_W'(ADDR_LIMIT)) | align_bad(mask_q, adr_q[1:0]);
`else
        sup_s = (adr_q > ADDR_W'(ADDR_LIMIT));
`endif
    end

    // State and latched-request registers; reset makes port 0 the first winner.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            port_q  <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            wdata_q <= '0;
            mask_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            port_q  <= port_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            wdata_q <= wdata_d;
            mask_q  <= mask_d;
            rdata_q <= rdata_d;
        end
    end

    // Next-state and output decode; gnt is masked during reset because it is combinational.
    always_comb begin
        state_d           = state_q;
        last_d            = last_q;
        port_d            = port_q;
        we_d              = we_q;
        adr_d             = adr_q;
        wdata_d           = wdata_q;
        mask_d            = mask_q;
        rdata_d           = rdata_q;
        bus.gnt0          = 1'b0;
        bus.gnt1          = 1'b0;
        bus.rvalid0       = 1'b0;
        bus.rvalid1       = 1'b0;
        bus.rdata0        = '0;
        bus.rdata1        = '0;
        bus.err0          = 1'b0;
        bus.err1          = 1'b0;
        bus.mrd           = 1'b0;
        bus.mwr           = 1'b0;
        bus.adr           = '0;
        bus.d_in          = '0;
        bus.data_out_mask = '0;

        case (state_q)
            IDLE: begin
                if (any_req_s && !rst) begin
                    bus.gnt0 = ~win_s;
                    bus.gnt1 = win_s;
                    port_d   = win_s;
                    last_d   = win_s;
                    we_d     = win_s ? bus.we1    : bus.we0;
                    adr_d    = win_s ? bus.adr1   : bus.adr0;
                    wdata_d  = win_s ? bus.wdata1 : bus.wdata0;
                    mask_d   = win_s ? bus.mask1  : bus.mask0;
                    state_d  = ACCESS;
                end else begin
                    state_d  = IDLE;
                end
            end
            ACCESS: begin
                bus.adr           = adr_q;
                bus.d_in          = wdata_q;
                bus.data_out_mask = mask_q;
                bus.mrd           = ~we_q & ~sup_s;
                bus.mwr           = we_q & ~sup_s;
                if (!we_q && !sup_s) begin
                    rdata_d = bus.d_out;
                end else begin
                    rdata_d = '0;
                end
                state_d = RESP;
            end
            RESP: begin
                if (port_q) begin
                    bus.rvalid1 = 1'b1;
                    bus.rdata1  = rdata_q;
                    bus.err1    = sup_s;
                end else begin
                    bus.rvalid0 = 1'b1;
                    bus.rdata0  = rdata_q;
                    bus.err0    = sup_s;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a byte-addressed memory model.
module tb_dmem_arbiter;
    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;

    logic [7:0] mem [0:65535];

    dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .ADDR_LIMIT(32'd65532)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wire [15:0] ra = bus.adr[15:0];
    assign bus.d_out = bus.mrd ? {mem[ra + 16'd3], mem[ra + 16'd2], mem[ra + 16'd1], mem[ra]} : 32'h0;

    // Memory model: cleared and preloaded while reset is high, byte-lane writes otherwise.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 65536; i++) mem[i] <= 8'h00;
            mem[1000]  <= 8'h78; mem[1001]  <= 8'h56; mem[1002]  <= 8'h34; mem[1003]  <= 8'h12;
            mem[65532] <= 8'h0D; mem[65533] <= 8'hF0; mem[65534] <= 8'hFE; mem[65535] <= 8'hCA;
        end else if (bus.mwr) begin
            for (int i = 0; i < 4; i++)
                if (bus.data_out_mask[i]) mem[ra + 16'(i)] <= bus.d_in[8*i +: 8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One full transaction from IDLE; ends at the falling edge of the RESP cycle.
    task automatic do_access(input string tag, input bit p, input bit we, input logic [31:0] a,
                             input logic [31:0] wd, input logic [3:0] m, input bit ok,
                             input logic [31:0] erd, input bit eerr);
        @(posedge clk); #1;
        if (p) begin
            bus.req1 = 1'b1; bus.we1 = we; bus.adr1 = a; bus.wdata1 = wd; bus.mask1 = m;
        end else begin
            bus.req0 = 1'b1; bus.we0 = we; bus.adr0 = a; bus.wdata0 = wd; bus.mask0 = m;
        end
        @(negedge clk);
        chk({tag, " gnt"},       {31'd0, p ? bus.gnt1 : bus.gnt0}, 32'd1);
        chk({tag, " gnt other"}, {31'd0, p ? bus.gnt0 : bus.gnt1}, 32'd0);
        @(posedge clk); #1;
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        @(negedge clk);
        chk({tag, " mrd"}, {31'd0, bus.mrd}, {31'd0, ok & ~we});
        chk({tag, " mwr"}, {31'd0, bus.mwr}, {31'd0, ok & we});
        if (ok) begin
            chk({tag, " adr"},  bus.adr, a);
            chk({tag, " mask"}, {28'd0, bus.data_out_mask}, {28'd0, m});
            if (we) chk({tag, " d_in"}, bus.d_in, wd);
        end
        @(negedge clk);
        chk({tag, " rvalid"},       {31'd0, p ? bus.rvalid1 : bus.rvalid0}, 32'd1);
        chk({tag, " rvalid other"}, {31'd0, p ? bus.rvalid0 : bus.rvalid1}, 32'd0);
        chk({tag, " rdata"},        p ? bus.rdata1 : bus.rdata0, erd);
        chk({tag, " err"},          {31'd0, p ? bus.err1 : bus.err0}, {31'd0, eerr});
        chk({tag, " mwr in resp"},  {31'd0, bus.mwr}, 32'd0);
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        rst = 1'b1;
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.adr0 = 32'd1000; bus.wdata0 = 32'h0; bus.mask0 = 4'b1111;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.adr1 = 32'd2000; bus.wdata1 = 32'h0; bus.mask1 = 4'b1111;

        // Reset: all outputs low even with requests pending.
        @(negedge clk);
        chk("reset gnt0",    {31'd0, bus.gnt0}, 32'd0);
        chk("reset gnt1",    {31'd0, bus.gnt1}, 32'd0);
        chk("reset mrd",     {31'd0, bus.mrd}, 32'd0);
        chk("reset mwr",     {31'd0, bus.mwr}, 32'd0);
        chk("reset rvalid0", {31'd0, bus.rvalid0}, 32'd0);
        chk("reset adr",     bus.adr, 32'd0);

        // Contention from reset: grants alternate 0,1,0,1 every 3 cycles.
        @(posedge clk); #1 rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk("cont gnt0",    {31'd0, bus.gnt0},    {31'd0, (k % 3 == 0) && ((k / 3) % 2 == 0)});
            chk("cont gnt1",    {31'd0, bus.gnt1},    {31'd0, (k % 3 == 0) && ((k / 3) % 2 == 1)});
            chk("cont rvalid0", {31'd0, bus.rvalid0}, {31'd0, (k % 3 == 2) && ((k / 3) % 2 == 0)});
            chk("cont rvalid1", {31'd0, bus.rvalid1}, {31'd0, (k % 3 == 2) && ((k / 3) % 2 == 1)});
            chk("cont mrd",     {31'd0, bus.mrd},     {31'd0, k % 3 == 1});
            if (k % 3 == 2) begin
                if ((k / 3) % 2 == 0) chk("cont rdata0", bus.rdata0, 32'h12345678);
                else                  chk("cont rdata1", bus.rdata1, 32'h00000000);
            end
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;

        do_access("read1000",   1'b0, 1'b0, 32'd1000,  32'h0,        4'b1111, 1'b1, 32'h12345678, 1'b0);
        do_access("bytewr",     1'b1, 1'b1, 32'd2000,  32'h000000AB, 4'b0001, 1'b1, 32'h0,        1'b0);
        do_access("readback",   1'b1, 1'b0, 32'd2000,  32'h0,        4'b1111, 1'b1, 32'h000000AB, 1'b0);
        do_access("oor write",  1'b0, 1'b1, 32'd65536, 32'hDEADBEEF, 4'b1111, 1'b0, 32'h0,        1'b1);
        do_access("limit read", 1'b0, 1'b0, 32'd65532, 32'h0,        4'b1111, 1'b1, 32'hCAFEF00D, 1'b0);
        do_access("above lim",  1'b1, 1'b0, 32'd65533, 32'h0,        4'b1111, 1'b0, 32'h0,        1'b1);
`ifdef DMEM_ARB_ALIGN_CHK_EN
        do_access("misalign",   1'b0, 1'b1, 32'd1001,  32'h11223344, 4'b1111, 1'b0, 32'h0,        1'b1);
`else
        do_access("misalign",   1'b0, 1'b1, 32'd1001,  32'h11223344, 4'b1111, 1'b1, 32'h0,        1'b0);
`endif

        // Reset during the ACCESS cycle of a write aborts it.
        @(posedge clk); #1;
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.adr0 = 32'd3000; bus.wdata0 = 32'hA5A5A5A5; bus.mask0 = 4'b1111;
        @(negedge clk);
        chk("abort gnt0", {31'd0, bus.gnt0}, 32'd1);
        @(posedge clk); #1 bus.req0 = 1'b0;
        @(negedge clk);
        chk("abort mwr before", {31'd0, bus.mwr}, 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("abort mwr async", {31'd0, bus.mwr}, 32'd0);
        @(negedge clk);
        chk("abort rvalid0", {31'd0, bus.rvalid0}, 32'd0);
        chk("abort rvalid1", {31'd0, bus.rvalid1}, 32'd0);
        chk("abort mem", {mem[3003], mem[3002], mem[3001], mem[3000]}, 32'h0);
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.req1 = 1'b1; bus.we1 = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("post-reset gnt0", {31'd0, bus.gnt0}, 32'd1);
        chk("post-reset gnt1", {31'd0, bus.gnt1}, 32'd0);
        @(posedge clk); #1 bus.req0 = 1'b0; bus.req1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("post-reset rvalid0", {31'd0, bus.rvalid0}, 32'd1);
        chk("post-reset rdata0",  bus.rdata0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
